// File: rtl/vp_119_amux.sv
// vp_119_amux: DRAM row/column address multiplexer and RAS-only refresh row counter.
// Define VP119_AMUX_REFWRAP_EN to add PIN_RWRAP, a one-clock pulse when the refresh counter wraps.
module vp_119_amux #(
  parameter int MA_WIDTH  = 8,
  parameter int COL_DELAY = 1
) (
  input  logic                PIN_CLK,
  input  logic                PIN_nDCLO,
  input  logic [21:0]         PIN_A,
  input  logic                PIN_nLA,
  input  logic                PIN_nRAS0,
  input  logic                PIN_nRAS1,
  input  logic                PIN_nCAS,
  output logic [MA_WIDTH-1:0] PIN_MA,
  output logic                PIN_MSEL,
  output logic                PIN_RFSH
`ifdef VP119_AMUX_REFWRAP_EN
  ,
  output logic                PIN_RWRAP
`endif
);
  typedef enum logic [1:0] {IDLE, ROW, COL, REFR} state_t;
  state_t              r_state, w_state_nxt;
  logic [20:0]         r_alat, w_alat_nxt;
  logic [MA_WIDTH-1:0] r_ma, w_ma_nxt, r_rcnt, w_rcnt_nxt;
  logic [MA_WIDTH-1:0] w_row, w_row_nxt, w_col;
  logic [1:0]          r_dcnt, w_dcnt_nxt;
  logic                r_msel, w_msel_nxt, r_rfsh, w_rfsh_nxt;
  logic                r_ras0, r_ras1, w_f0, w_f1, w_up;
  logic                w_unused;
`ifdef VP119_AMUX_REFWRAP_EN
  logic                r_rwrap, w_rwrap_nxt;
  assign PIN_RWRAP = r_rwrap;
`endif
  // r_alat holds ALAT[21:1], so index 0 is bus address bit 1
  assign w_alat_nxt = PIN_nLA ? r_alat : PIN_A[21:1];
  assign w_row      = r_alat[MA_WIDTH-1:0];
  assign w_row_nxt  = w_alat_nxt[MA_WIDTH-1:0];
  assign w_col      = r_alat[2*MA_WIDTH-1:MA_WIDTH];
  assign w_f0       = r_ras0 & ~PIN_nRAS0;
  assign w_f1       = r_ras1 & ~PIN_nRAS1;
  assign w_up       = PIN_nRAS0 & PIN_nRAS1;
  assign w_unused   = ^{PIN_A[0], r_alat[20:2*MA_WIDTH], w_row};
  assign PIN_MA     = r_ma;
  assign PIN_MSEL   = r_msel;
  assign PIN_RFSH   = r_rfsh;

  always_comb begin
    w_state_nxt = r_state;
    w_ma_nxt    = r_ma;
    w_msel_nxt  = r_msel;
    w_rfsh_nxt  = r_rfsh;
    w_dcnt_nxt  = r_dcnt;
    w_rcnt_nxt  = r_rcnt;
`ifdef VP119_AMUX_REFWRAP_EN
    w_rwrap_nxt = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        w_ma_nxt   = w_row_nxt;
        w_msel_nxt = 1'b0;
        if (w_f0 && w_f1) begin
          w_state_nxt = REFR;
          w_ma_nxt    = r_rcnt;
          w_rfsh_nxt  = 1'b1;
        end else if (w_f0 || w_f1) begin
          w_state_nxt = ROW;
          w_dcnt_nxt  = 2'(COL_DELAY);
        end
      end
      ROW: begin
        // RAS release aborts the access before any column is issued
        if (w_up) begin
          w_state_nxt = IDLE;
          w_ma_nxt    = w_row_nxt;
          w_msel_nxt  = 1'b0;
          w_dcnt_nxt  = 2'd0;
        end else if (!PIN_nCAS || r_dcnt <= 2'd1) begin
          w_state_nxt = COL;
          w_ma_nxt    = w_col;
          w_msel_nxt  = 1'b1;
          w_dcnt_nxt  = 2'd0;
        end else begin
          w_dcnt_nxt  = r_dcnt - 2'd1;
        end
      end
      COL: begin
        if (w_up) begin
          w_state_nxt = IDLE;
          w_ma_nxt    = w_row_nxt;
          w_msel_nxt  = 1'b0;
        end
      end
      default: begin
        if (w_up) begin
          w_state_nxt = IDLE;
          w_ma_nxt    = w_row_nxt;
          w_rfsh_nxt  = 1'b0;
          w_rcnt_nxt  = r_rcnt + MA_WIDTH'(1);
`ifdef VP119_AMUX_REFWRAP_EN
          w_rwrap_nxt = &r_rcnt;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge PIN_CLK or negedge PIN_nDCLO) begin
    if (!PIN_nDCLO) begin
      r_state <= IDLE;
      r_alat  <= '0;
      r_rcnt  <= '0;
      r_ma    <= '0;
      r_msel  <= 1'b0;
      r_rfsh  <= 1'b0;
      r_dcnt  <= 2'd0;
      r_ras0  <= 1'b1;
      r_ras1  <= 1'b1;
`ifdef VP119_AMUX_REFWRAP_EN
      r_rwrap <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_alat  <= w_alat_nxt;
      r_rcnt  <= w_rcnt_nxt;
      r_ma    <= w_ma_nxt;
      r_msel  <= w_msel_nxt;
      r_rfsh  <= w_rfsh_nxt;
      r_dcnt  <= w_dcnt_nxt;
      r_ras0  <= PIN_nRAS0;
      r_ras1  <= PIN_nRAS1;
`ifdef VP119_AMUX_REFWRAP_EN
      r_rwrap <= w_rwrap_nxt;
`endif
    end
  end
endmodule

// File: tb/tb_vp_119_amux.sv
// tb_vp_119_amux: scoreboard bench for vp_119_amux; dut1 uses COL_DELAY=1, dut3 uses COL_DELAY=3, same stimulus.
module tb_vp_119_amux;
  typedef struct packed {logic nla; logic [21:0] a; logic r0; logic r1; logic c;} stim_t;
  typedef struct packed {logic [7:0] ma; logic msel; logic rfsh;} exp_t;

  localparam logic [21:0] A1 = 22'o00014000;
  localparam logic [21:0] A2 = 22'o00000377;
  localparam logic [21:0] A6 = 22'o00001776;

  logic clk = 1'b0;
  logic rst_n, nla, nras0, nras1, ncas;
  logic [21:0] a;
  logic [7:0] ma1, ma3;
  logic msel1, msel3, rfsh1, rfsh3;
`ifdef VP119_AMUX_REFWRAP_EN
  logic rwrap1, rwrap3;
`endif
  int checks = 0;
  int failures = 0;
  int rc = 0;
  exp_t sb1[$];
  exp_t sb3[$];

  always #5 clk = ~clk;

  vp_119_amux #(.MA_WIDTH(8), .COL_DELAY(1)) dut1 (
    .PIN_CLK(clk), .PIN_nDCLO(rst_n), .PIN_A(a), .PIN_nLA(nla), .PIN_nRAS0(nras0),
    .PIN_nRAS1(nras1), .PIN_nCAS(ncas), .PIN_MA(ma1), .PIN_MSEL(msel1), .PIN_RFSH(rfsh1)
`ifdef VP119_AMUX_REFWRAP_EN
    , .PIN_RWRAP(rwrap1)
`endif
  );

  vp_119_amux #(.MA_WIDTH(8), .COL_DELAY(3)) dut3 (
    .PIN_CLK(clk), .PIN_nDCLO(rst_n), .PIN_A(a), .PIN_nLA(nla), .PIN_nRAS0(nras0),
    .PIN_nRAS1(nras1), .PIN_nCAS(ncas), .PIN_MA(ma3), .PIN_MSEL(msel3), .PIN_RFSH(rfsh3)
`ifdef VP119_AMUX_REFWRAP_EN
    , .PIN_RWRAP(rwrap3)
`endif
  );

  task automatic drive(input stim_t s);
    nla = s.nla; a = s.a; nras0 = s.r0; nras1 = s.r1; ncas = s.c;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; nla = 1'b1; a = '0; nras0 = 1'b1; nras1 = 1'b1; ncas = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ma1, msel1, rfsh1, ma3, msel3, rfsh3} !== 20'h0) begin
      failures++;
      $display("FAIL reset outputs got %h exp 0", {ma1, msel1, rfsh1, ma3, msel3, rfsh3});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_col;
    stim_t st[6];
    exp_t e1[6], e3[6];
    exp_t x;
    st = '{'{1'b0, A1, 1'b1, 1'b1, 1'b1}, '{1'b1, A1, 1'b0, 1'b1, 1'b1}, '{1'b1, A1, 1'b0, 1'b1, 1'b1},
           '{1'b1, A1, 1'b0, 1'b1, 1'b1}, '{1'b1, A1, 1'b0, 1'b1, 1'b1}, '{1'b1, A1, 1'b1, 1'b1, 1'b1}};
    e1 = '{'{8'h00, 1'b0, 1'b0}, '{8'h00, 1'b0, 1'b0}, '{8'h0C, 1'b1, 1'b0},
           '{8'h0C, 1'b1, 1'b0}, '{8'h0C, 1'b1, 1'b0}, '{8'h00, 1'b0, 1'b0}};
    e3 = '{'{8'h00, 1'b0, 1'b0}, '{8'h00, 1'b0, 1'b0}, '{8'h00, 1'b0, 1'b0},
           '{8'h00, 1'b0, 1'b0}, '{8'h0C, 1'b1, 1'b0}, '{8'h00, 1'b0, 1'b0}};
    for (int i = 0; i < 6; i++) begin
      sb1.push_back(e1[i]);
      sb3.push_back(e3[i]);
      drive(st[i]);
      x = sb1.pop_front();
      checks++;
      if ({ma1, msel1, rfsh1} !== x) begin
        failures++;
        $display("FAIL basic_col[%0d] dut1 ma/msel/rfsh got %h exp %h", i, {ma1, msel1, rfsh1}, x);
      end
      x = sb3.pop_front();
      checks++;
      if ({ma3, msel3, rfsh3} !== x) begin
        failures++;
        $display("FAIL basic_col[%0d] dut3 ma/msel/rfsh got %h exp %h", i, {ma3, msel3, rfsh3}, x);
      end
    end
  endtask

  task automatic test_early_cas;
    stim_t st[4];
    exp_t e[4];
    exp_t x;
    st = '{'{1'b0, A2, 1'b1, 1'b1, 1'b1}, '{1'b1, A2, 1'b1, 1'b0, 1'b0},
           '{1'b1, A2, 1'b1, 1'b0, 1'b0}, '{1'b1, A2, 1'b1, 1'b1, 1'b1}};
    e = '{'{8'h7F, 1'b0, 1'b0}, '{8'h7F, 1'b0, 1'b0}, '{8'h00, 1'b1, 1'b0}, '{8'h7F, 1'b0, 1'b0}};
    for (int i = 0; i < 4; i++) begin
      sb1.push_back(e[i]);
      sb3.push_back(e[i]);
      drive(st[i]);
      x = sb1.pop_front();
      checks++;
      if ({ma1, msel1, rfsh1} !== x) begin
        failures++;
        $display("FAIL early_cas[%0d] dut1 got %h exp %h", i, {ma1, msel1, rfsh1}, x);
      end
      x = sb3.pop_front();
      checks++;
      if ({ma3, msel3, rfsh3} !== x) begin
        failures++;
        $display("FAIL early_cas[%0d] dut3 got %h exp %h", i, {ma3, msel3, rfsh3}, x);
      end
    end
  endtask

  // 257 refresh cycles: the full sweep plus one to see the wrap back to 0; nCAS toggled to show it is ignored
  task automatic test_refresh;
    stim_t s;
    exp_t x;
    logic wrap_exp;
    for (int i = 0; i < 257; i++) begin
      for (int p = 0; p < 3; p++) begin
        s = '{1'b1, A2, p == 2, p == 2, p != 1};
        sb1.push_back(p == 2 ? exp_t'({8'h7F, 1'b0, 1'b0}) : exp_t'({rc[7:0], 1'b0, 1'b1}));
        sb3.push_back(p == 2 ? exp_t'({8'h7F, 1'b0, 1'b0}) : exp_t'({rc[7:0], 1'b0, 1'b1}));
        wrap_exp = (p == 2) && (rc == 255);
        drive(s);
        x = sb1.pop_front();
        checks++;
        if ({ma1, msel1, rfsh1} !== x) begin
          failures++;
          $display("FAIL refresh[%0d.%0d] dut1 got %h exp %h", i, p, {ma1, msel1, rfsh1}, x);
        end
        x = sb3.pop_front();
        checks++;
        if ({ma3, msel3, rfsh3} !== x) begin
          failures++;
          $display("FAIL refresh[%0d.%0d] dut3 got %h exp %h", i, p, {ma3, msel3, rfsh3}, x);
        end
`ifdef VP119_AMUX_REFWRAP_EN
        checks++;
        if (rwrap1 !== wrap_exp || rwrap3 !== wrap_exp) begin
          failures++;
          $display("FAIL rwrap[%0d.%0d] got %b%b exp %b", i, p, rwrap1, rwrap3, wrap_exp);
        end
`endif
        if (p == 2) rc = (rc + 1) % 256;
      end
    end
  endtask

  task automatic test_abort;
    stim_t st[4];
    exp_t e[4];
    exp_t x;
    st = '{'{1'b1, A2, 1'b0, 1'b1, 1'b1}, '{1'b1, A2, 1'b1, 1'b1, 1'b1},
           '{1'b1, A2, 1'b0, 1'b0, 1'b1}, '{1'b1, A2, 1'b1, 1'b1, 1'b1}};
    e = '{'{8'h7F, 1'b0, 1'b0}, '{8'h7F, 1'b0, 1'b0}, '{rc[7:0], 1'b0, 1'b1}, '{8'h7F, 1'b0, 1'b0}};
    for (int i = 0; i < 4; i++) begin
      sb1.push_back(e[i]);
      sb3.push_back(e[i]);
      drive(st[i]);
      x = sb1.pop_front();
      checks++;
      if ({ma1, msel1, rfsh1} !== x) begin
        failures++;
        $display("FAIL abort[%0d] dut1 got %h exp %h", i, {ma1, msel1, rfsh1}, x);
      end
      x = sb3.pop_front();
      checks++;
      if ({ma3, msel3, rfsh3} !== x) begin
        failures++;
        $display("FAIL abort[%0d] dut3 got %h exp %h", i, {ma3, msel3, rfsh3}, x);
      end
    end
    rc = (rc + 1) % 256;
  endtask

  task automatic test_async_reset;
    stim_t s;
    exp_t x;
    for (int i = 0; i < 3; i++) begin
      s = '{i != 0, A1, i == 0, 1'b1, 1'b1};
      sb1.push_back(i == 2 ? exp_t'({8'h0C, 1'b1, 1'b0}) : exp_t'({8'h00, 1'b0, 1'b0}));
      drive(s);
      x = sb1.pop_front();
      checks++;
      if ({ma1, msel1, rfsh1} !== x) begin
        failures++;
        $display("FAIL rst_col_setup[%0d] got %h exp %h", i, {ma1, msel1, rfsh1}, x);
      end
    end
    #2 rst_n = 1'b0; nla = 1'b1; nras0 = 1'b1; nras1 = 1'b1; ncas = 1'b1;
    #1;
    checks++;
    if ({ma1, msel1, rfsh1, ma3, msel3, rfsh3} !== 20'h0) begin
      failures++;
      $display("FAIL rst_mid_col got %h exp 0", {ma1, msel1, rfsh1, ma3, msel3, rfsh3});
    end
    rst_n = 1'b1;
    rc = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 11; i++) begin
      s = '{1'b1, 22'h0, i[0], i[0], 1'b1};
      sb1.push_back(i[0] ? exp_t'({8'h00, 1'b0, 1'b0}) : exp_t'({rc[7:0], 1'b0, 1'b1}));
      drive(s);
      x = sb1.pop_front();
      checks++;
      if ({ma1, msel1, rfsh1} !== x) begin
        failures++;
        $display("FAIL rst_refr_setup[%0d] got %h exp %h", i, {ma1, msel1, rfsh1}, x);
      end
      if (i[0]) rc++;
    end
    checks++;
    if (ma3 !== 8'h05 || rfsh3 !== 1'b1) begin
      failures++;
      $display("FAIL rst_refr_count5 dut3 got %h/%b exp 05/1", ma3, rfsh3);
    end
    #2 rst_n = 1'b0; nras0 = 1'b1; nras1 = 1'b1;
    #1;
    checks++;
    if ({ma1, msel1, rfsh1, ma3, msel3, rfsh3} !== 20'h0) begin
      failures++;
      $display("FAIL rst_mid_refr got %h exp 0", {ma1, msel1, rfsh1, ma3, msel3, rfsh3});
    end
    rst_n = 1'b1;
    rc = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      s = '{1'b1, 22'h0, i == 1, i == 1, 1'b1};
      sb3.push_back(i == 1 ? exp_t'({8'h00, 1'b0, 1'b0}) : exp_t'({8'h00, 1'b0, 1'b1}));
      drive(s);
      x = sb3.pop_front();
      checks++;
      if ({ma3, msel3, rfsh3} !== x) begin
        failures++;
        $display("FAIL rst_rcnt_restart[%0d] dut3 got %h exp %h", i, {ma3, msel3, rfsh3}, x);
      end
    end
    rc = 1;
  endtask

  task automatic test_bypass;
    stim_t st[3];
    exp_t e1[3], e3[3];
    exp_t x;
    st = '{'{1'b0, A6, 1'b0, 1'b1, 1'b1}, '{1'b1, A6, 1'b0, 1'b1, 1'b1}, '{1'b1, A6, 1'b1, 1'b1, 1'b1}};
    e1 = '{'{8'hFF, 1'b0, 1'b0}, '{8'h01, 1'b1, 1'b0}, '{8'hFF, 1'b0, 1'b0}};
    e3 = '{'{8'hFF, 1'b0, 1'b0}, '{8'hFF, 1'b0, 1'b0}, '{8'hFF, 1'b0, 1'b0}};
    for (int i = 0; i < 3; i++) begin
      sb1.push_back(e1[i]);
      sb3.push_back(e3[i]);
      drive(st[i]);
      x = sb1.pop_front();
      checks++;
      if ({ma1, msel1, rfsh1} !== x) begin
        failures++;
        $display("FAIL bypass[%0d] dut1 got %h exp %h", i, {ma1, msel1, rfsh1}, x);
      end
      x = sb3.pop_front();
      checks++;
      if ({ma3, msel3, rfsh3} !== x) begin
        failures++;
        $display("FAIL bypass[%0d] dut3 got %h exp %h", i, {ma3, msel3, rfsh3}, x);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic_col;
    test_early_cas;
    test_refresh;
    test_abort;
    test_async_reset;
    test_bypass;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
